// File: rtl/neural_soc_sysid_checker.sv
// Avalon-MM master that reads the system-ID slave (ID word, then timestamp) and reports pass/fail.
// Optional: SYSID_CHECK_AUTOSTART_EN fires one internal start on the first clock edge after reset release.
module neural_soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1480283514,
  parameter int unsigned READ_LATENCY       = 0,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout_err,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_CHECK, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  retry_q, retry_d;
  logic [15:0] tmo_q, tmo_d;
  logic [2:0]  lat_q, lat_d;
  logic        pass_q, pass_d;
  logic        tmo_err_q, tmo_err_d;
  logic [31:0] cap_id_q, cap_id_d;
  logic [31:0] cap_ts_q, cap_ts_d;
  logic        start_int;
  logic        accept;

`ifdef SYSID_CHECK_AUTOSTART_EN
  logic auto_q;

  // High only between reset release and the first clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) auto_q <= 1'b1;
    else          auto_q <= 1'b0;
  end

  assign start_int = start | auto_q;
`else
  assign start_int = start;
`endif

  // Read strobe is decoded from state so it drops asynchronously with reset.
  assign avm_read    = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign avm_address = (state_q == S_RD_TS);
  assign accept      = avm_read && !avm_waitrequest;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign timeout_err = tmo_err_q;
  assign captured_id = cap_id_q;
  assign captured_ts = cap_ts_q;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    tmo_d     = tmo_q;
    lat_d     = lat_q;
    pass_d    = pass_q;
    tmo_err_d = tmo_err_q;
    cap_id_d  = cap_id_q;
    cap_ts_d  = cap_ts_q;
    case (state_q)
      S_IDLE: begin
        if (start_int) begin
          state_d   = S_RD_ID;
          pass_d    = 1'b0;
          tmo_err_d = 1'b0;
          retry_d   = '0;
          tmo_d     = '0;
        end
      end
      S_RD_ID: begin
        if (accept) begin
          lat_d = '0;
          if (READ_LATENCY == 0) begin
            cap_id_d = avm_readdata;
            state_d  = S_RD_TS;
            tmo_d    = '0;
          end else begin
            state_d = S_LAT_ID;
          end
        end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_LAT_ID: begin
        if (lat_q == 3'(READ_LATENCY - 1)) begin
          cap_id_d = avm_readdata;
          state_d  = S_RD_TS;
          tmo_d    = '0;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RD_TS: begin
        if (accept) begin
          lat_d = '0;
          if (READ_LATENCY == 0) begin
            cap_ts_d = avm_readdata;
            state_d  = S_CHECK;
          end else begin
            state_d = S_LAT_TS;
          end
        end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d   = S_DONE;
          tmo_err_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_LAT_TS: begin
        if (lat_q == 3'(READ_LATENCY - 1)) begin
          cap_ts_d = avm_readdata;
          state_d  = S_CHECK;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_CHECK: begin
        if ((cap_id_q == EXPECTED_ID) && (cap_ts_q == EXPECTED_TIMESTAMP)) begin
          state_d = S_DONE;
          pass_d  = 1'b1;
        end else if (retry_q < 4'(MAX_RETRIES)) begin
          retry_d = retry_q + 4'd1;
          state_d = S_RD_ID;
          tmo_d   = '0;
        end else begin
          state_d = S_DONE;
          pass_d  = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      retry_q   <= '0;
      tmo_q     <= '0;
      lat_q     <= '0;
      pass_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      cap_id_q  <= '0;
      cap_ts_q  <= '0;
    end else begin
      state_q   <= state_d;
      retry_q   <= retry_d;
      tmo_q     <= tmo_d;
      lat_q     <= lat_d;
      pass_q    <= pass_d;
      tmo_err_q <= tmo_err_d;
      cap_id_q  <= cap_id_d;
      cap_ts_q  <= cap_ts_d;
    end
  end

endmodule

// File: tb/tb_neural_soc_sysid_checker.sv
// Directed bench: instance A uses default timing, instance B uses READ_LATENCY=2, TIMEOUT_CYCLES=10.
module tb_neural_soc_sysid_checker;

  localparam logic [31:0] EXP_TS   = 32'd1480283514;
  localparam logic [31:0] EXP_ID_B = 32'h1234_5678;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  logic        a_start, a_wait, a_addr, a_read, a_busy, a_done, a_pass, a_tmo;
  logic [31:0] a_rdata, a_cid, a_cts;
  logic        b_start, b_wait, b_addr, b_read, b_busy, b_done, b_pass, b_tmo;
  logic [31:0] b_rdata, b_cid, b_cts;

  neural_soc_sysid_checker #(
    .EXPECTED_ID(32'd0), .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(0), .TIMEOUT_CYCLES(255), .MAX_RETRIES(3)
  ) u_a (
    .clock(clock), .reset_n(reset_n), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_readdata(a_rdata),
    .avm_waitrequest(a_wait), .busy(a_busy), .done(a_done), .pass(a_pass),
    .timeout_err(a_tmo), .captured_id(a_cid), .captured_ts(a_cts)
  );

  neural_soc_sysid_checker #(
    .EXPECTED_ID(EXP_ID_B), .EXPECTED_TIMESTAMP(EXP_TS),
    .READ_LATENCY(2), .TIMEOUT_CYCLES(10), .MAX_RETRIES(3)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read), .avm_readdata(b_rdata),
    .avm_waitrequest(b_wait), .busy(b_busy), .done(b_done), .pass(b_pass),
    .timeout_err(b_tmo), .captured_id(b_cid), .captured_ts(b_cts)
  );

  // Slave A: zero-latency; timestamp is wrong for reads numbered below a_bad_until.
  logic [31:0] a_ts_val;
  int          a_rd_cnt   = 0;
  int          a_done_cnt = 0;
  int          a_bad_until;
  assign a_rdata = a_addr ? ((a_rd_cnt < a_bad_until) ? EXP_TS + 32'd1 : a_ts_val) : 32'd0;
  always @(posedge clock) begin
    if (a_read && !a_wait) a_rd_cnt <= a_rd_cnt + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
  end

  // Slave B: data valid for exactly one cycle, two cycles after accept.
  logic p1v = 1'b0, p2v = 1'b0, p1a = 1'b0, p2a = 1'b0;
  always @(posedge clock) begin
    p1v <= b_read && !b_wait;
    p1a <= b_addr;
    p2v <= p1v;
    p2a <= p1a;
  end
  assign b_rdata = p2v ? (p2a ? EXP_TS : EXP_ID_B) : 32'hBAD0_BAD0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input bit sel_b, input int lim, input string tag);
    int n = 0;
    while (!(sel_b ? b_done : a_done) && n < lim) begin
      @(negedge clock);
      n++;
    end
    check(tag, {31'd0, (sel_b ? b_done : a_done)}, 32'd1);
  endtask

  int base_rd, base_dn;

  initial begin
    reset_n = 1'b0; a_start = 1'b0; a_wait = 1'b0; b_start = 1'b0; b_wait = 1'b0;
    a_ts_val = EXP_TS; a_bad_until = 0;
    repeat (2) @(negedge clock);
    check("rst_a_busy", {31'd0, a_busy}, 32'd0);
    check("rst_a_read", {31'd0, a_read}, 32'd0);
    check("rst_a_done", {31'd0, a_done}, 32'd0);
    check("rst_a_pass", {31'd0, a_pass}, 32'd0);
    check("rst_a_cts", a_cts, 32'd0);
    check("rst_b_read", {31'd0, b_read}, 32'd0);
    reset_n = 1'b1;
`ifdef SYSID_CHECK_AUTOSTART_EN
    wait_done(1'b0, 50, "auto_a_done");
    @(negedge clock);
`else
    repeat (3) @(negedge clock);
    check("idle_a_busy", {31'd0, a_busy}, 32'd0);
    check("idle_a_reads", a_rd_cnt, 32'd0);
`endif
    repeat (20) @(negedge clock);

    // Test 1: nominal pass, exact timing
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    check("t1_rd_id", {30'd0, a_read, a_addr}, 32'd2);
    @(negedge clock);
    check("t1_rd_ts", {30'd0, a_read, a_addr}, 32'd3);
    @(negedge clock);
    check("t1_check_done", {30'd0, a_done, a_busy}, 32'd1);
    @(negedge clock);
    check("t1_done", {31'd0, a_done}, 32'd1);
    check("t1_pass", {31'd0, a_pass}, 32'd1);
    check("t1_cts", a_cts, EXP_TS);
    check("t1_cid", a_cid, 32'd0);
    @(negedge clock);
    check("t1_after", {29'd0, a_done, a_busy, a_pass}, 32'd1);

    // Test 2: persistent timestamp mismatch exhausts retries
    base_rd = a_rd_cnt; base_dn = a_done_cnt;
    a_ts_val = EXP_TS + 32'd1;
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    wait_done(1'b0, 100, "t2_done");
    check("t2_reads", a_rd_cnt - base_rd, 32'd8);
    check("t2_pass", {31'd0, a_pass}, 32'd0);
    check("t2_tmo", {31'd0, a_tmo}, 32'd0);
    check("t2_cts", a_cts, EXP_TS + 32'd1);
    @(negedge clock);
    check("t2_done_cnt", a_done_cnt - base_dn, 32'd1);

    // Test 3: mismatch twice then match
    a_ts_val = EXP_TS;
    base_rd = a_rd_cnt; base_dn = a_done_cnt;
    a_bad_until = a_rd_cnt + 4;
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    wait_done(1'b0, 100, "t3_done");
    check("t3_reads", a_rd_cnt - base_rd, 32'd6);
    check("t3_pass", {31'd0, a_pass}, 32'd1);
    @(negedge clock);
    check("t3_done_cnt", a_done_cnt - base_dn, 32'd1);

    // Test 4: stuck bus on B, timeout after 10 stall cycles
    b_wait = 1'b1;
    b_start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock); b_start = 1'b0;
      check($sformatf("t4_read_%0d", i), {31'd0, b_read}, 32'd1);
    end
    @(negedge clock);
    check("t4_dropped", {31'd0, b_read}, 32'd0);
    check("t4_done", {31'd0, b_done}, 32'd1);
    check("t4_tmo", {31'd0, b_tmo}, 32'd1);
    check("t4_pass", {31'd0, b_pass}, 32'd0);
    b_wait = 1'b0;
    @(negedge clock);
    check("t4_idle", {31'd0, b_busy}, 32'd0);

    // Test 5: READ_LATENCY=2 with stalls
    b_start = 1'b1; b_wait = 1'b1;
    @(negedge clock); b_start = 1'b0;
    check("t5_stall_a0", {30'd0, b_read, b_addr}, 32'd2);
    @(negedge clock);
    check("t5_stall_a1", {30'd0, b_read, b_addr}, 32'd2);
    b_wait = 1'b0;
    @(negedge clock);
    check("t5_lat_id", {30'd0, b_read, b_busy}, 32'd1);
    b_wait = 1'b1;
    @(negedge clock);
    @(negedge clock);
    check("t5_ts_stall_a", {30'd0, b_read, b_addr}, 32'd3);
    check("t5_cid", b_cid, EXP_ID_B);
    @(negedge clock);
    check("t5_ts_stall_b", {30'd0, b_read, b_addr}, 32'd3);
    b_wait = 1'b0;
    repeat (4) @(negedge clock);
    check("t5_done", {31'd0, b_done}, 32'd1);
    check("t5_pass", {31'd0, b_pass}, 32'd1);
    check("t5_tmo", {31'd0, b_tmo}, 32'd0);
    check("t5_cts", b_cts, EXP_TS);

    // Test 6a: start while busy and in the DONE cycle is ignored
    base_rd = a_rd_cnt;
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    @(negedge clock); a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    @(negedge clock);
    check("t6_done", {31'd0, a_done}, 32'd1);
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    check("t6_ign_busy", {31'd0, a_busy}, 32'd0);
    @(negedge clock);
    check("t6_ign_busy2", {31'd0, a_busy}, 32'd0);
    check("t6_reads", a_rd_cnt - base_rd, 32'd2);

    // Test 6b: reset during RD_TS
    a_start = 1'b1;
    @(negedge clock); a_start = 1'b0;
    @(negedge clock);
    check("t6_in_rdts", {30'd0, a_read, a_addr}, 32'd3);
    reset_n = 1'b0;
    #1;
    check("t6_rst_read", {31'd0, a_read}, 32'd0);
    check("t6_rst_busy", {31'd0, a_busy}, 32'd0);
    check("t6_rst_cts", a_cts, 32'd0);
    check("t6_rst_b_pass", {31'd0, b_pass}, 32'd0);
    @(negedge clock);
    base_rd = a_rd_cnt;
    reset_n = 1'b1;
`ifdef SYSID_CHECK_AUTOSTART_EN
    wait_done(1'b0, 50, "t6_auto_done");
    check("t6_auto_pass", {31'd0, a_pass}, 32'd1);
`else
    repeat (4) @(negedge clock);
    check("t6_post_busy", {31'd0, a_busy}, 32'd0);
    check("t6_post_reads", a_rd_cnt - base_rd, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
